// File: rtl/count_slot_arbiter_pkg.sv
// Shared definitions for the count-slot arbiter: state encoding, default
// sizes and the round-robin index helpers.
package count_slot_arbiter_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefNReq  = 4;

    // Index width sized for the largest supported requester count (8).
    localparam int unsigned IdxW = 3;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Advance an index by one, wrapping at n.
    function automatic logic [IdxW-1:0] rr_inc(input logic [IdxW-1:0] idx,
                                               input int unsigned n);
        if (32'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

    // First requester at or above ptr (with wrap at n) whose req bit is set.
    function automatic logic [IdxW-1:0] rr_pick(input logic [7:0] req,
                                                input logic [IdxW-1:0] ptr,
                                                input int unsigned n);
        logic [IdxW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/count_slot_arbiter_count.sv
// count_core: shared synchronous up-counter with clear and enable.
module count_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Clear wins over enable; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_slot_arbiter.sv
// Round-robin arbiter that lends one shared counter to a requester at a time,
// runs it to that requester's terminal count and pulses its done.
module count_slot_arbiter
    import count_slot_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] len_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [WIDTH-1:0]       count_o
);

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] winner_q, winner_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [7:0]      req_pad;
    logic [WIDTH-1:0] len_sel;
    logic            req_win;
    logic            cnt_clear;
    logic            cnt_en;

    count_core #(
        .WIDTH(WIDTH)
    ) u_count_core (
        .clk    (clk),
        .rst    (rst),
        .clear_i(cnt_clear),
        .en_i   (cnt_en),
        .count_o(count_o)
    );

    // Widen req to the fixed index space and pick out the winner's length.
    always_comb begin
        req_pad = '0;
        len_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_pad[i] = req_i[i];
            if (winner_q == 3'(i)) begin
                len_sel = len_i[i*WIDTH +: WIDTH];
            end
        end
        req_win = req_pad[winner_q];
    end

    // Slot sequencing: pick, load, run to terminal count, report.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        len_d     = len_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    winner_d = rr_pick(req_pad, ptr_q, N_REQ);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                cnt_clear = 1'b1;
                if (!req_win) begin
                    // Abort still moves the pointer past the winner.
                    ptr_d   = rr_inc(winner_q, N_REQ);
                    state_d = StIdle;
                end else begin
                    len_d   = len_sel;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!req_win) begin
                    cnt_clear = 1'b1;
                    ptr_d     = rr_inc(winner_q, N_REQ);
                    state_d   = StIdle;
                end else if (count_o == len_q) begin
                    state_d = StDone;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StDone: begin
                ptr_d   = rr_inc(winner_q, N_REQ);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer, winner and frozen length registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            winner_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            len_q    <= len_d;
        end
    end

    // Outputs decode only from registered state and winner.
    always_comb begin
        busy_o  = (state_q != StIdle);
        grant_o = '0;
        done_o  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_o[i] = busy_o && (winner_q == 3'(i));
            done_o[i]  = (state_q == StDone) && (winner_q == 3'(i));
        end
    end

endmodule
